// File: rtl/soc_wb_pkg.sv
// Shared definitions for the SoC Wishbone fabric: arbiter state encoding and
// the default read data returned on a timed-out transaction.
package soc_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester found when scanning
// upward from (last+1) mod N_MST wins.
module rr_pick #(
    parameter int N_MST = 2,
    parameter int IW    = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic [N_MST-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // cand[k] is the master examined at scan position k (k=0 is highest priority)
    logic [IW-1:0] cand [N_MST];

    for (genvar gi = 0; gi < N_MST; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(last) + gi + 1) % N_MST);
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: one master per transaction, a guard cycle
// between transactions, and a bus-error ack when the slave never answers.
module wb_arbiter_rr
    import soc_wb_pkg::*;
#(
    parameter int             N_MST    = 2,
    parameter int             DW       = 32,
    parameter int             AW       = 16,
    parameter int             TIMEOUT  = 255,
    parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_MST*AW-1:0]   m_addr,
    input  logic [N_MST*DW-1:0]   m_wdata,
    input  logic [N_MST*DW/8-1:0] m_wmsk,
    input  logic [N_MST-1:0]      m_we,
    input  logic [N_MST-1:0]      m_cyc,
    output logic [N_MST-1:0]      m_ack,
    output logic [DW-1:0]         m_rdata,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    output logic [DW/8-1:0]       s_wmsk,
    output logic                  s_we,
    output logic                  s_cyc,
    input  logic                  s_ack,
    input  logic [DW-1:0]         s_rdata,
    output logic                  err,
    output logic [1:0]            err_mst,
    input  logic                  err_clr
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int MW = DW / 8;

    state_t        state_reg, state_next;
    logic [IW-1:0] gnt_reg, gnt_next;
    logic [IW-1:0] last_reg, last_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
    logic [1:0]    err_mst_reg, err_mst_next;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    logic [AW-1:0] addr_arr  [N_MST];
    logic [DW-1:0] wdata_arr [N_MST];
    logic [MW-1:0] wmsk_arr  [N_MST];

    logic busy, req_live, ack_fire, timeout_hit;

    for (genvar gi = 0; gi < N_MST; gi++) begin : g_split
        assign addr_arr[gi]  = m_addr[gi*AW +: AW];
        assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
        assign wmsk_arr[gi]  = m_wmsk[gi*MW +: MW];
        assign m_ack[gi]     = (ack_fire || timeout_hit) && (gnt_reg == IW'(gi));
    end

    rr_pick #(
        .N_MST (N_MST),
        .IW    (IW)
    ) u_pick (
        .req   (m_cyc),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A master that has dropped cyc gets neither a forwarded ack nor a timeout.
    assign busy        = (state_reg == ST_BUSY);
    assign req_live    = m_cyc[gnt_reg];
    assign ack_fire    = busy && req_live && s_ack;
    assign timeout_hit = busy && req_live && !s_ack && (cnt_reg == CW'(TIMEOUT));

    // Slave-side muxes are gated by BUSY so idle outputs stay at zero.
    assign s_cyc   = busy && req_live && !timeout_hit;
    assign s_addr  = busy ? addr_arr[gnt_reg]  : '0;
    assign s_wdata = busy ? wdata_arr[gnt_reg] : '0;
    assign s_wmsk  = busy ? wmsk_arr[gnt_reg]  : '0;
    assign s_we    = busy && m_we[gnt_reg];
    assign m_rdata = !busy ? '0 : (timeout_hit ? ERR_DATA : s_rdata);

    assign err     = err_reg;
    assign err_mst = err_mst_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            last_reg    <= IW'(N_MST - 1);
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            err_mst_reg <= 2'b00;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            err_mst_reg <= err_mst_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        err_mst_next = err_mst_reg;

        // A timeout in the same cycle overrides the clear below.
        if (err_clr) begin
            err_next = 1'b0;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_next   = pick_idx;
                    last_next  = pick_idx;
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req_live || ack_fire) begin
                    state_next = ST_GUARD;
                end else if (timeout_hit) begin
                    err_next     = 1'b1;
                    err_mst_next = 2'(gnt_reg);
                    state_next   = ST_GUARD;
                end else if (cnt_reg != CW'(TIMEOUT)) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_GUARD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (2 masters, TIMEOUT=8). Inputs change on
// the falling edge, outputs are sampled 1 time unit later.
module tb_wb_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmsk;
    logic [1:0]  m_we;
    logic [1:0]  m_cyc;
    logic [1:0]  m_ack;
    logic [31:0] m_rdata;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmsk;
    logic        s_we;
    logic        s_cyc;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        err;
    logic [1:0]  err_mst;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] ADDR0 = 16'hA000;
    localparam logic [15:0] ADDR1 = 16'hB111;

    always #5 clk = ~clk;

    wb_arbiter_rr #(
        .N_MST   (2),
        .DW      (32),
        .AW      (16),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wmsk  (m_wmsk),
        .m_we    (m_we),
        .m_cyc   (m_cyc),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wmsk  (s_wmsk),
        .s_we    (s_we),
        .s_cyc   (s_cyc),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .err     (err),
        .err_mst (err_mst),
        .err_clr (err_clr)
    );

    task automatic test_reset();
        m_cyc = 2'b11;
        s_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_m_ack got=%b exp=00", m_ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_mst !== 2'd0) begin errors++; $display("FAIL reset_err_mst got=%0d exp=0", err_mst); end
        checks++; if (s_addr !== 16'h0) begin errors++; $display("FAIL reset_s_addr got=%h exp=0000", s_addr); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got=%h exp=00000000", m_rdata); end
        @(negedge clk);
        m_cyc = 2'b00;
        s_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_single();
        @(negedge clk);
        m_cyc = 2'b01;
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_idle_s_cyc got=%b exp=0", s_cyc); end
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL single_s_cyc_rise got=%b exp=1", s_cyc); end
        checks++; if (s_addr !== ADDR0) begin errors++; $display("FAIL single_s_addr got=%h exp=%h", s_addr, ADDR0); end
        checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL single_s_we got=%b exp=0", s_we); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_early_ack got=%b exp=00", m_ack); end
        @(negedge clk); #1;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_wait_ack got=%b exp=00", m_ack); end
        @(negedge clk);
        s_ack   = 1'b1;
        s_rdata = 32'hCAFE0001;
        #1;
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL single_m_ack got=%b exp=01", m_ack); end
        checks++; if (m_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_m_rdata got=%h exp=cafe0001", m_rdata); end
        @(negedge clk);
        s_ack = 1'b0;
        m_cyc = 2'b00;
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_guard_s_cyc got=%b exp=0", s_cyc); end
        @(negedge clk);
        $display("single: m0 read addr=%h data=cafe0001", ADDR0);
    endtask

    task automatic test_late_ack();
        @(negedge clk);
        m_cyc = 2'b10;
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL late_s_cyc got=%b exp=1", s_cyc); end
        checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL late_s_we got=%b exp=1", s_we); end
        checks++; if (s_wdata !== 32'h11112222) begin errors++; $display("FAIL late_s_wdata got=%h exp=11112222", s_wdata); end
        checks++; if (s_wmsk !== 4'hC) begin errors++; $display("FAIL late_s_wmsk got=%h exp=c", s_wmsk); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL late_m_ack got=%b exp=10", m_ack); end
        @(negedge clk);
        m_cyc = 2'b00;
        #1;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL late_guard_ack got=%b exp=00", m_ack); end
        @(negedge clk); #1;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL late_idle_ack got=%b exp=00", m_ack); end
        s_ack = 1'b0;
        $display("late_ack: m1 write, slave ack held through guard/idle");
    endtask

    task automatic test_contention();
        int n, gap, cyc, exp_m;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_cyc = 2'b11;
        n = 0; gap = 0; cyc = 0;
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            s_ack = 1'b0;
            #1;
            cyc++;
            if (s_cyc === 1'b1) begin
                exp_m = n % 2;
                if (n > 0) begin
                    // guard cycle plus the arbitration cycle
                    checks++; if (gap != 2) begin errors++; $display("FAIL cont_gap txn=%0d got=%0d exp=2", n, gap); end
                end
                s_ack   = 1'b1;
                s_rdata = 32'h50000000 + n;
                #1;
                checks++; if (m_ack !== (2'b01 << exp_m)) begin errors++; $display("FAIL cont_m_ack txn=%0d got=%b exp_master=%0d", n, m_ack, exp_m); end
                checks++; if (s_addr !== ((exp_m == 1) ? ADDR1 : ADDR0)) begin errors++; $display("FAIL cont_s_addr txn=%0d got=%h exp_master=%0d", n, s_addr, exp_m); end
                $display("contention: txn %0d m_ack=%b s_addr=%h", n, m_ack, s_addr);
                n++;
                gap = 0;
            end else begin
                gap++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL cont_count got=%0d exp=8", n); end
        @(negedge clk);
        s_ack = 1'b0;
        m_cyc = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int mst, k;
        for (int r = 0; r < 2; r++) begin
            mst = (r == 0) ? 1 : 0;
            @(negedge clk);
            m_cyc = 2'b01 << mst;
            k = 0;
            while (s_cyc !== 1'b1 && k < 10) begin
                @(negedge clk); #1; k++;
            end
            checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL to_start round=%0d got=%b exp=1", r, s_cyc); end
            for (int b = 2; b <= 8; b++) begin
                @(negedge clk); #1;
                checks++; if (m_ack !== 2'b00 || s_cyc !== 1'b1) begin errors++; $display("FAIL to_wait round=%0d busy=%0d m_ack=%b s_cyc=%b exp=00/1", r, b, m_ack, s_cyc); end
            end
            if (r == 0) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_before got=%b exp=0", err); end
            end
            @(negedge clk);
            err_clr = (r == 1);
            #1;
            checks++; if (m_ack !== (2'b01 << mst)) begin errors++; $display("FAIL to_m_ack round=%0d got=%b exp_master=%0d", r, m_ack, mst); end
            checks++; if (m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_m_rdata round=%0d got=%h exp=deadbeef", r, m_rdata); end
            checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL to_s_cyc round=%0d got=%b exp=0", r, s_cyc); end
            @(negedge clk);
            err_clr = 1'b0;
            m_cyc   = 2'b00;
            #1;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err round=%0d got=%b exp=1", r, err); end
            checks++; if (err_mst !== 2'(mst)) begin errors++; $display("FAIL to_err_mst round=%0d got=%0d exp=%0d", r, err_mst, mst); end
            $display("timeout: round %0d master %0d err=%b err_mst=%0d", r, mst, err, err_mst);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clr got=%b exp=0", err); end
    endtask

    task automatic test_abort();
        int k;
        @(negedge clk);
        m_cyc = 2'b10;
        k = 0;
        while (s_cyc !== 1'b1 && k < 10) begin
            @(negedge clk); #1; k++;
        end
        checks++; if (s_addr !== ADDR1 || s_cyc !== 1'b1) begin errors++; $display("FAIL abort_start s_addr=%h s_cyc=%b exp=%h/1", s_addr, s_cyc, ADDR1); end
        @(negedge clk);
        m_cyc = 2'b01;
        #1;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL abort_m_ack got=%b exp=00", m_ack); end
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL abort_s_cyc got=%b exp=0", s_cyc); end
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin errors++; $display("FAIL abort_guard s_cyc=%b m_ack=%b exp=0/00", s_cyc, m_ack); end
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL abort_idle s_cyc=%b exp=0", s_cyc); end
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b1 || s_addr !== ADDR0) begin errors++; $display("FAIL abort_next s_cyc=%b s_addr=%h exp=1/%h", s_cyc, s_addr, ADDR0); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL abort_next_ack got=%b exp=01", m_ack); end
        @(negedge clk);
        s_ack = 1'b0;
        m_cyc = 2'b00;
        @(negedge clk);
        $display("abort: m1 aborted, m0 served next");
    endtask

    task automatic test_reset_mid_busy();
        int k;
        @(negedge clk);
        m_cyc = 2'b01;
        k = 0;
        while (s_cyc !== 1'b1 && k < 10) begin
            @(negedge clk); #1; k++;
        end
        checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL rmb_start got=%b exp=1", s_cyc); end
        @(negedge clk);
        m_cyc = 2'b11;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rmb_s_cyc got=%b exp=0", s_cyc); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rmb_m_ack got=%b exp=00", m_ack); end
        checks++; if (s_addr !== 16'h0 || m_rdata !== 32'h0) begin errors++; $display("FAIL rmb_outputs s_addr=%h m_rdata=%h exp=0/0", s_addr, m_rdata); end
        @(negedge clk);
        s_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rmb_idle got=%b exp=0", s_cyc); end
        @(negedge clk); #1;
        checks++; if (s_cyc !== 1'b1 || s_addr !== ADDR0) begin errors++; $display("FAIL rmb_first_gnt s_cyc=%b s_addr=%h exp=1/%h", s_cyc, s_addr, ADDR0); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL rmb_ack got=%b exp=01", m_ack); end
        @(negedge clk);
        s_ack = 1'b0;
        m_cyc = 2'b00;
        @(negedge clk);
        $display("reset_mid_busy: m0 regranted after release");
    endtask

    initial begin
        rst_n   = 1'b0;
        m_addr  = {ADDR1, ADDR0};
        m_wdata = {32'h11112222, 32'h00000000};
        m_wmsk  = {4'hC, 4'hF};
        m_we    = 2'b10;
        m_cyc   = 2'b00;
        s_ack   = 1'b0;
        s_rdata = 32'h0;
        err_clr = 1'b0;

        test_reset();
        test_single();
        test_late_ack();
        test_contention();
        test_timeout();
        test_abort();
        test_reset_mid_busy();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
